// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial subtractor that computes diff = x - y - b_in (mod 2^WIDTH) LSB
// first, one bit per clock. It uses a single full-subtractor cell and one
// borrow flip-flop. The operands are captured when start is accepted in IDLE.
// The block then spends WIDTH cycles in SHIFT and one cycle in DONE. The
// result outputs change only on the SHIFT->DONE edge and hold their value
// until the next operation completes.
//
// Parameters
//   WIDTH  : operand width in bits, 2..32 (default 8)
//
// Ports
//   clk    : in,  clock, rising edge
//   rst    : in,  asynchronous active-high reset
//   start  : in,  one-cycle request, sampled only in IDLE
//   x      : in,  WIDTH, minuend (captured on accepted start)
//   y      : in,  WIDTH, subtrahend (captured on accepted start)
//   b_in   : in,  borrow-in (captured on accepted start)
//   diff   : out, WIDTH, x - y - b_in mod 2^WIDTH
//   b_out  : out, final borrow (1 when x < y + b_in, unsigned)
//   ovf    : out, signed overflow flag (only with SERIAL_SUB_SIGNED_OVF_EN)
//   busy   : out, high while in SHIFT
//   done   : out, one-cycle pulse in DONE
//
// Build option
//   SERIAL_SUB_SIGNED_OVF_EN : when defined, adds the ovf output. It is set on
//                              completion when the operand signs differ and the
//                              sign of the result differs from the sign of x.
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             b_in,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;

  logic [WIDTH-1:0] xr;       // minuend, consumed from bit 0
  logic [WIDTH-1:0] yr;       // subtrahend, consumed from bit 0
  logic [WIDTH-1:0] dr;       // result bits, shifted in at the MSB
  logic             br;       // running borrow
  logic [CW-1:0]    count;    // index of the bit being processed

  logic             cell_d;   // full-subtractor difference bit
  logic             cell_b;   // full-subtractor borrow-out
  logic             last_bit; // processing the MSB in this cycle

  // ---------------------------------------------------------------------------
  // Full-subtractor cell. The difference bit is the XOR of the three inputs.
  // A borrow is generated when x=0 and y=1. It is propagated when x==y and a
  // borrow came in.
  // ---------------------------------------------------------------------------
  assign cell_d   = xr[0] ^ yr[0] ^ br;
  assign cell_b   = (~xr[0] & yr[0]) | (~(xr[0] ^ yr[0]) & br);

  assign last_bit = (state == SHIFT) && (count == CW'(WIDTH - 1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples values from before the edge, whatever the order of the
  // always blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment comes first so that every path assigns
  // state_nx and no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last_bit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // ---------------------------------------------------------------------------
  // Datapath: operand capture, serial processing, and result update.
  // A start in SHIFT or DONE never reaches the load branch, so it is dropped.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr    <= '0;
      yr    <= '0;
      dr    <= '0;
      br    <= 1'b0;
      count <= '0;
      diff  <= '0;
      b_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            xr    <= x;
            yr    <= y;
            br    <= b_in;
            dr    <= '0;
            count <= '0;
          end
        end
        SHIFT: begin
          xr <= xr >> 1;
          yr <= yr >> 1;
          br <= cell_b;
          dr <= {cell_d, dr[WIDTH-1:1]};
          if (last_bit) begin
            // The visible result is taken from the combinational cell output,
            // so it appears on the same edge that enters DONE.
            diff  <= {cell_d, dr[WIDTH-1:1]};
            b_out <= cell_b;
            count <= '0;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  // ---------------------------------------------------------------------------
  // Signed overflow. In the final SHIFT cycle xr[0] and yr[0] hold the sign
  // bits of the captured operands, and cell_d is the sign bit of the result.
  // No extra capture register is needed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (last_bit) begin
      ovf <= (xr[0] != yr[0]) && (cell_d != xr[0]);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Two instances of serial_subtractor are tested, one at WIDTH=8 and one at
// WIDTH=2. The stimulus task pushes the expected result into a per-instance
// queue when it issues an operation. A monitor per instance pops that queue
// and compares the outputs whenever done is high. The reference model is plain
// integer arithmetic on the captured operands.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;

  logic       start8, b8;
  logic [7:0] x8, y8, diff8;
  logic       bout8, busy8, done8;

  logic       start2, b2;
  logic [1:0] x2, y2, diff2;
  logic       bout2, busy2, done2;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic       ovf8, ovf2;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] d;
    logic        bo;
    logic        ov;
  } exp_t;

  exp_t q8[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .x     (x8),
    .y     (y8),
    .b_in  (b8),
    .diff  (diff8),
    .b_out (bout8),
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    .ovf   (ovf8),
`endif
    .busy  (busy8),
    .done  (done8)
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .rst   (rst),
    .start (start2),
    .x     (x2),
    .y     (y2),
    .b_in  (b2),
    .diff  (diff2),
    .b_out (bout2),
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    .ovf   (ovf2),
`endif
    .busy  (busy2),
    .done  (done2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: arithmetic on the whole operands, not bit by bit.
  function automatic exp_t model(input int w, input logic [31:0] x, input logic [31:0] y,
                                 input logic b);
    exp_t   e;
    longint mask;
    longint r;
    mask = (longint'(1) << w) - 1;
    r    = longint'(x) - longint'(y) - longint'(b);
    e.d  = 32'(r & mask);
    e.bo = (longint'(x) < (longint'(y) + longint'(b)));
    e.ov = (x[w-1] != y[w-1]) && (e.d[w-1] != x[w-1]);
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitors: compare on every done pulse against the head of the queue.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin : mon8
    exp_t e;
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        check("w8_spurious_done", {31'b0, done8}, 32'd0);
      end else begin
        e = q8.pop_front();
        check("w8_diff", {24'b0, diff8}, e.d);
        check("w8_b_out", {31'b0, bout8}, {31'b0, e.bo});
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        check("w8_ovf", {31'b0, ovf8}, {31'b0, e.ov});
`endif
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (done2 === 1'b1) begin
      if (q2.size() == 0) begin
        check("w2_spurious_done", {31'b0, done2}, 32'd0);
      end else begin
        e = q2.pop_front();
        check("w2_diff", {30'b0, diff2}, e.d);
        check("w2_b_out", {31'b0, bout2}, {31'b0, e.bo});
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        check("w2_ovf", {31'b0, ovf2}, {31'b0, e.ov});
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Issue one operation on instance sel (0: WIDTH=8, 1: WIDTH=2). The task
  // returns at the negedge where done is seen, so the next call starts in the
  // IDLE cycle that follows DONE (back-to-back). When disturb is set, start is
  // pulsed and the operands are scrambled mid-SHIFT.
  // ---------------------------------------------------------------------------
  task automatic run_op(input bit sel, input logic [31:0] x, input logic [31:0] y,
                        input logic b, input bit disturb);
    int   w;
    int   lat;
    int   busy_n;
    bit   seen;
    exp_t e;
    w      = sel ? 2 : 8;
    lat    = 0;
    busy_n = 0;
    seen   = 0;
    e      = model(w, x, y, b);
    @(negedge clk);
    if (sel) begin
      x2 = x[1:0]; y2 = y[1:0]; b2 = b; start2 = 1'b1;
      q2.push_back(e);
    end else begin
      x8 = x[7:0]; y8 = y[7:0]; b8 = b; start8 = 1'b1;
      q8.push_back(e);
    end
    @(posedge clk);
    #1;
    start8 = 1'b0;
    start2 = 1'b0;
    for (int k = 1; k <= w + 4 && !seen; k++) begin
      @(negedge clk);
      if (sel ? busy2 : busy8) busy_n++;
      if (sel ? done2 : done8) begin
        seen = 1;
        lat  = k;
      end
      if (disturb && k == 3) begin
        x8 = 8'($urandom); y8 = 8'($urandom); b8 = ~b8; start8 = 1'b1;
      end else if (disturb && k == 4) begin
        start8 = 1'b0;
      end
    end
    check(sel ? "w2_latency" : "w8_latency", lat, w + 1);
    check(sel ? "w2_busy_cycles" : "w8_busy_cycles", busy_n, w);
  endtask

  // Global bound so that a stuck design cannot hang the run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    start8 = 1'b0; x8 = '0; y8 = '0; b8 = 1'b0;
    start2 = 1'b0; x2 = '0; y2 = '0; b2 = 1'b0;

    #12;
    check("rst_busy8", {31'b0, busy8}, 32'd0);
    check("rst_done8", {31'b0, done8}, 32'd0);
    check("rst_diff8", {24'b0, diff8}, 32'd0);
    check("rst_bout8", {31'b0, bout8}, 32'd0);
    check("rst_diff2", {30'b0, diff2}, 32'd0);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    check("rst_ovf8", {31'b0, ovf8}, 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed cases at WIDTH=8, with literal expectations as well.
    run_op(0, 32'h05, 32'h03, 1'b0, 0);
    check("d_05_03_diff", {24'b0, diff8}, 32'h02);
    check("d_05_03_bout", {31'b0, bout8}, 32'd0);
    run_op(0, 32'h03, 32'h05, 1'b0, 0);
    check("d_03_05_diff", {24'b0, diff8}, 32'hFE);
    check("d_03_05_bout", {31'b0, bout8}, 32'd1);
    run_op(0, 32'h00, 32'h00, 1'b1, 0);
    check("d_00_00_b1_diff", {24'b0, diff8}, 32'hFF);
    check("d_00_00_b1_bout", {31'b0, bout8}, 32'd1);

    // Start and operand changes during SHIFT are ignored; exactly one done.
    run_op(0, 32'hAA, 32'h55, 1'b0, 1);
    check("d_aa_55_diff", {24'b0, diff8}, 32'h55);
    check("d_aa_55_bout", {31'b0, bout8}, 32'd0);
    repeat (12) @(negedge clk);
    check("d_aa_55_hold", {24'b0, diff8}, 32'h55);

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    run_op(0, 32'h80, 32'h01, 1'b0, 0);
    check("ovf_80_01_diff", {24'b0, diff8}, 32'h7F);
    check("ovf_80_01", {31'b0, ovf8}, 32'd1);
    run_op(0, 32'h7F, 32'hFF, 1'b0, 0);
    check("ovf_7f_ff_diff", {24'b0, diff8}, 32'h80);
    check("ovf_7f_ff", {31'b0, ovf8}, 32'd1);
    run_op(0, 32'h05, 32'h03, 1'b0, 0);
    check("ovf_05_03", {31'b0, ovf8}, 32'd0);
`endif

    // Reset during SHIFT: abort with no done and no partial result.
    @(negedge clk);
    x8 = 8'h5A; y8 = 8'h33; b8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy8}, 32'd0);
    check("abort_done", {31'b0, done8}, 32'd0);
    check("abort_diff", {24'b0, diff8}, 32'd0);
    check("abort_bout", {31'b0, bout8}, 32'd0);
    repeat (11) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_diff_after", {24'b0, diff8}, 32'd0);
    run_op(0, 32'h5A, 32'h33, 1'b0, 0);
    check("after_abort_diff", {24'b0, diff8}, 32'h27);

    // Random back-to-back runs on both widths.
    for (int i = 0; i < 1000; i++)
      run_op(0, $urandom & 32'hFF, $urandom & 32'hFF, 1'($urandom % 2), 0);
    for (int i = 0; i < 1000; i++)
      run_op(1, $urandom & 32'h3, $urandom & 32'h3, 1'($urandom % 2), 0);

    repeat (5) @(negedge clk);
    check("w8_queue_empty", q8.size(), 32'd0);
    check("w2_queue_empty", q2.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits, legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, a one-cycle request that is sampled only in IDLE.
REQ-005 The block SHALL have port x, input, WIDTH bits, the minuend, captured on accepted start.
REQ-006 The block SHALL have port y, input, WIDTH bits, the subtrahend, captured on accepted start.
REQ-007 The block SHALL have port b_in, input, 1 bit, the borrow-in, captured on accepted start.
REQ-008 The block SHALL have port diff, output, WIDTH bits, the result x - y - b_in mod 2^WIDTH.
REQ-009 The block SHALL have port b_out, output, 1 bit, the final borrow: 1 when x < y + b_in unsigned.
REQ-010 The block SHALL have port busy, output, 1 bit, high while in the SHIFT state.
REQ-011 The block SHALL have port done, output, 1 bit, a one-cycle pulse in the DONE state.

Function
REQ-012 The block SHALL compute LSB-first, one bit per cycle, through a single full-subtractor cell and one borrow flip-flop.
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-014 IDLE -> SHIFT on start=1; load x, y, borrow<=b_in, count<=0; the diff shift register is cleared.
REQ-015 Each SHIFT cycle SHALL compute d=xr[0]^yr[0]^br and br<=(~xr[0]&yr[0])|(~(xr[0]^yr[0])&br), shift xr and yr right, and shift d into the MSB of the result register.
REQ-016 SHIFT -> DONE when count==WIDTH-1 after processing that bit; otherwise count<=count+1.
REQ-017 DONE -> IDLE unconditionally after one cycle; done=1 only in DONE.
REQ-018 Latency: with start accepted at edge N, done SHALL be high in the cycle after edge N+WIDTH; total WIDTH+1 cycles start-to-done.
REQ-019 diff and b_out SHALL update only on the SHIFT->DONE transition, holding the final value until the next such transition.
REQ-020 start SHALL be ignored in SHIFT and DONE; there is no queueing.
REQ-021 Changes on x, y or b_in after capture SHALL NOT affect the operation in progress.
REQ-022 Back-to-back operation: start asserted in the IDLE cycle immediately after DONE SHALL be accepted; throughput is one result per WIDTH+2 cycles.

Reset
REQ-023 Asserting rst SHALL force IDLE immediately, regardless of clk.
REQ-024 On reset, diff, b_out, busy, done, count, the borrow and all shift registers SHALL be 0.
REQ-025 Reset during SHIFT SHALL abort the operation without a done pulse; no partial result SHALL appear on diff.
REQ-026 The first start SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-027 The macro SERIAL_SUB_SIGNED_OVF_EN SHALL control an added output ovf, 1 bit, reset 0.
REQ-028 When SERIAL_SUB_SIGNED_OVF_EN is defined, ovf SHALL be set at SHIFT->DONE to (x[MSB]!=y[MSB]) && (diff[MSB]!=x[MSB]), using the captured operands, and SHALL be held like diff.
REQ-029 When SERIAL_SUB_SIGNED_OVF_EN is undefined, port ovf and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-030 x=0x05, y=0x03, b_in=0 -> diff=0x02, b_out=0, busy high 8 cycles, done exactly 9 cycles after start edge.
REQ-031 x=0x03, y=0x05, b_in=0 -> diff=0xFE, b_out=1; x=0x00, y=0x00, b_in=1 -> diff=0xFF, b_out=1.
REQ-032 x=0xAA, y=0x55, b_in=0 -> diff=0x55, b_out=0, with start pulsed again and x/y changed during SHIFT -> ignored, result unchanged, single done.
REQ-033 rst asserted mid-SHIFT after 4 bit-cycles -> busy=0, done never pulses, diff=0x00, b_out=0; a new start after release gives the correct result.
REQ-034 With SERIAL_SUB_SIGNED_OVF_EN: 0x80-0x01 -> diff=0x7F, ovf=1; 0x7F-0xFF -> diff=0x80, ovf=1; 0x05-0x03 -> ovf=0.
REQ-035 The bench SHALL compare every result against a reference model, including random back-to-back operations for 1000 runs at WIDTH=8 and WIDTH=2.
